// File: rtl/pingpong_sample_buffer.sv
// Double-buffered multi-channel sample capture: writer fills one bank while the reader owns the other.
// Read latency 1 cycle; frames arriving while both banks are full are dropped and counted.
module pingpong_sample_buffer #(
    parameter int SAMPLE_W   = 8,
    parameter int DEPTH_BITS = 9,
    parameter int NUM_CH     = 2,
    parameter int CH_BITS    = 1
) (
    input  logic                       sys_clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic                       wr_valid,
    input  logic [NUM_CH*SAMPLE_W-1:0] wr_data,
    input  logic                       rd_en,
    input  logic [CH_BITS-1:0]         rd_ch,
    input  logic [DEPTH_BITS-1:0]      rd_addr,
    input  logic                       rd_done,
    input  logic                       ovr_clr,
    output logic [SAMPLE_W-1:0]        rd_data,
    output logic                       rd_valid,
    output logic                       bank_ready,
    output logic                       ready_pulse,
    output logic                       wr_bank,
    output logic                       overrun,
    output logic [15:0]                drop_cnt
);

    localparam int BANK_WORDS = 2 ** (DEPTH_BITS + 1);
    localparam logic [DEPTH_BITS-1:0] LAST_ADDR = '1;

    typedef enum logic {FILL, HOLD} state_t;

    state_t                  state;
    logic [DEPTH_BITS-1:0]   wr_addr;
    logic [CH_BITS-1:0]      rd_ch_q;
    logic                    rd_zero;
    logic [SAMPLE_W-1:0]     q_all [NUM_CH];

    logic                    wr_fire;
    logic                    done_fire;
    logic                    rd_fire;
    logic                    mem_we;
    logic                    drop;
    logic                    swap_fill;
    logic                    ch_ok;
    logic [31:0]             rd_ch_ext;
    logic [DEPTH_BITS:0]     waddr;
    logic [DEPTH_BITS:0]     raddr;

    assign wr_fire   = en & wr_valid;
    assign done_fire = en & rd_done;
    assign rd_fire   = en & rd_en & bank_ready;
    assign mem_we    = wr_fire & (state == FILL);
    assign drop      = wr_fire & (state == HOLD);
    // Completing a bank hands it over immediately if the reader is free or releasing right now.
    assign swap_fill = mem_we & (wr_addr == LAST_ADDR) & (~bank_ready | done_fire);
    assign rd_ch_ext = 32'(rd_ch);
    assign ch_ok     = rd_ch_ext < 32'(NUM_CH);
    assign waddr     = {wr_bank, wr_addr};
    assign raddr     = {~wr_bank, rd_addr};

    // One simple-dual-port RAM per channel; the read register lives inside so it maps to BRAM.
    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [SAMPLE_W-1:0] mem [BANK_WORDS];
        logic [SAMPLE_W-1:0] q;

        always_ff @(posedge sys_clk) begin
            if (mem_we) begin
                mem[waddr] <= wr_data[c*SAMPLE_W +: SAMPLE_W];
            end
            if (rd_fire) begin
                q <= mem[raddr];
            end
        end

        assign q_all[c] = q;
    end

    assign rd_data = rd_zero ? '0 : q_all[rd_ch_q];

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            state       <= FILL;
            wr_addr     <= '0;
            wr_bank     <= 1'b0;
            bank_ready  <= 1'b0;
            ready_pulse <= 1'b0;
            overrun     <= 1'b0;
            drop_cnt    <= '0;
            rd_valid    <= 1'b0;
            rd_zero     <= 1'b1;
            rd_ch_q     <= '0;
        end else begin
            ready_pulse <= 1'b0;
            rd_valid    <= rd_fire;

            if (rd_fire) begin
                rd_ch_q <= rd_ch;
                rd_zero <= ~ch_ok;
            end

            if (ovr_clr) begin
                overrun  <= 1'b0;
                drop_cnt <= '0;
            end else if (drop) begin
                overrun <= 1'b1;
                if (drop_cnt != 16'hFFFF) begin
                    drop_cnt <= drop_cnt + 16'd1;
                end
            end

            if (en) begin
                case (state)
                    FILL: begin
                        if (mem_we) begin
                            wr_addr <= wr_addr + 1'b1;
                            if (wr_addr == LAST_ADDR) begin
                                if (swap_fill) begin
                                    wr_bank     <= ~wr_bank;
                                    bank_ready  <= 1'b1;
                                    ready_pulse <= 1'b1;
                                end else begin
                                    state <= HOLD;
                                end
                            end
                        end
                        if (done_fire && bank_ready && !swap_fill) begin
                            bank_ready <= 1'b0;
                        end
                    end
                    HOLD: begin
                        if (done_fire) begin
                            wr_bank     <= ~wr_bank;
                            wr_addr     <= '0;
                            ready_pulse <= 1'b1;
                            state       <= FILL;
                        end
                    end
                    default: state <= FILL;
                endcase
            end
        end
    end

endmodule
